// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x4 active-low matrix keypad one row at a time,
// synchronizes the column lines, and debounces whole-frame scan results
// before presenting a stable keycode/ready pair plus a one-cycle press strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [4:0] row_n,
    output logic [4:0] keycode,
    output logic       ready,
    output logic       press
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        CNT_MAX  = 4'(DEBOUNCE_SCANS);

    // Column synchronizer
    logic [3:0]       col_meta_q, col_sync_q;
    // Row scan
    logic [2:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       row_n_q, row_n_d;
    // Per-frame hit accumulator
    logic             acc_hit_q, acc_hit_d;
    logic [4:0]       acc_code_q, acc_code_d;
    // Debounce candidate and stability counter
    logic             cand_hit_q, cand_hit_d;
    logic [4:0]       cand_code_q, cand_code_d;
    logic [3:0]       cnt_q, cnt_d;
    // Debounced outputs
    logic             ready_q, ready_d;
    logic [4:0]       keycode_q, keycode_d;
    logic             press_q, press_d;

    logic             sample_s, frame_end_s;
    logic             col_hit_s;
    logic [1:0]       col_idx_s;
    logic             res_hit_s;
    logic [4:0]       res_code_s;
    logic             res_equal_s;
    logic             accept_s;

    // Two-flop synchronizer on the asynchronous column inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Lowest-indexed active column of the synchronized sample
    always_comb begin
        col_hit_s = 1'b1;
        col_idx_s = 2'd0;
        if (!col_sync_q[0]) begin
            col_idx_s = 2'd0;
        end else if (!col_sync_q[1]) begin
            col_idx_s = 2'd1;
        end else if (!col_sync_q[2]) begin
            col_idx_s = 2'd2;
        end else if (!col_sync_q[3]) begin
            col_idx_s = 2'd3;
        end else begin
            col_hit_s = 1'b0;
        end
    end

    // Dwell counter and row advance; row_n changes on the same edge the counter wraps
    always_comb begin
        sample_s    = (div_q == DIV_LAST);
        frame_end_s = sample_s && (row_q == 3'd4);
        div_d       = div_q + DIV_W'(1);
        row_d       = row_q;
        if (sample_s) begin
            div_d = {DIV_W{1'b0}};
            row_d = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
        end else begin
            row_d = row_q;
        end
        row_n_d = ~(5'b00001 << row_d);
    end

    // Frame result: first hit of the frame wins, including the row-4 sample itself
    always_comb begin
        res_hit_s  = acc_hit_q | (sample_s & col_hit_s);
        res_code_s = acc_hit_q ? acc_code_q : {row_q, col_idx_s};
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (frame_end_s) begin
            acc_hit_d  = 1'b0;
            acc_code_d = 5'd0;
        end else if (sample_s && col_hit_s && !acc_hit_q) begin
            acc_hit_d  = 1'b1;
            acc_code_d = {row_q, col_idx_s};
        end else begin
            acc_hit_d  = acc_hit_q;
            acc_code_d = acc_code_q;
        end
    end

    // Debounce: count consecutive identical frame results; no-key results always match
    always_comb begin
        res_equal_s = (res_hit_s == cand_hit_q) && (!res_hit_s || (res_code_s == cand_code_q));
        cand_hit_d  = cand_hit_q;
        cand_code_d = cand_code_q;
        cnt_d       = cnt_q;
        if (frame_end_s) begin
            if (res_equal_s) begin
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            end else begin
                cand_hit_d  = res_hit_s;
                cand_code_d = res_code_s;
                cnt_d       = 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Accept a stable candidate that differs from the debounced state
    always_comb begin
        accept_s  = (cnt_q == CNT_MAX) &&
                    ((cand_hit_q != ready_q) || (cand_hit_q && (cand_code_q != keycode_q)));
        ready_d   = ready_q;
        keycode_d = keycode_q;
        press_d   = 1'b0;
        if (accept_s) begin
            ready_d   = cand_hit_q;
            keycode_d = cand_hit_q ? cand_code_q : 5'd0;
            press_d   = cand_hit_q;
        end else begin
            press_d   = 1'b0;
        end
    end

    // State registers for scan, accumulator, debounce and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= 3'd0;
            div_q       <= {DIV_W{1'b0}};
            row_n_q     <= 5'b11110;
            acc_hit_q   <= 1'b0;
            acc_code_q  <= 5'd0;
            cand_hit_q  <= 1'b0;
            cand_code_q <= 5'd0;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b0;
            keycode_q   <= 5'd0;
            press_q     <= 1'b0;
        end else begin
            row_q       <= row_d;
            div_q       <= div_d;
            row_n_q     <= row_n_d;
            acc_hit_q   <= acc_hit_d;
            acc_code_q  <= acc_code_d;
            cand_hit_q  <= cand_hit_d;
            cand_code_q <= cand_code_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            keycode_q   <= keycode_d;
            press_q     <= press_d;
        end
    end

    assign row_n   = row_n_q;
    assign keycode = keycode_q;
    assign ready   = ready_q;
    assign press   = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix answers the row drive,
// a table of key patterns is applied frame-aligned, and expected outcomes
// are queued at drive time and checked when each window closes.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 5 * SD;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_n;
    logic [4:0] row_n;
    logic [4:0] keycode;
    logic       ready;
    logic       press;

    logic [19:0] keys;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [19:0] keys;
        int          frames;
        logic        exp_ready;
        logic [4:0]  exp_code;
        int          exp_press;
        int          exp_rise;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .col_n   (col_n),
        .row_n   (row_n),
        .keycode (keycode),
        .ready   (ready),
        .press   (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [19:0] k, input int f, input logic r,
                                input logic [4:0] c, input int p, input int ri);
        vec_t v;
        v.keys = k; v.frames = f; v.exp_ready = r; v.exp_code = c;
        v.exp_press = p; v.exp_rise = ri;
        return v;
    endfunction

    // Drive a key pattern for whole frames; count press pulses and ready rises
    task automatic run_window(input vec_t v, input string tag);
        vec_t e;
        int   presses;
        int   rises;
        logic prev;
        keys = v.keys;
        exp_q.push_back(v);
        presses = 0;
        rises   = 0;
        prev    = ready;
        repeat (v.frames * FRAME) begin
            @(posedge clk);
            @(negedge clk);
            if (press) presses++;
            if (ready && !prev) rises++;
            prev = ready;
        end
        e = exp_q.pop_front();
        chk({tag, " ready"},   int'(ready),   int'(e.exp_ready));
        chk({tag, " keycode"}, int'(keycode), int'(e.exp_code));
        chk({tag, " presses"}, presses,       e.exp_press);
        chk({tag, " rises"},   rises,         e.exp_rise);
    endtask

    initial begin
        logic [4:0] exp_row;
        int         idle_bad;
        n_cmp = 0;
        n_bad = 0;
        keys  = 20'd0;
        rst_n = 1'b0;

        vecs[0]  = mk(20'(1) << 13, 2, 1'b0, 5'd0,  0, 0);
        vecs[1]  = mk(20'(1) << 13, 1, 1'b1, 5'd13, 1, 1);
        vecs[2]  = mk(20'(1) << 13, 5, 1'b1, 5'd13, 0, 0);
        vecs[3]  = mk(20'd0,        2, 1'b1, 5'd13, 0, 0);
        vecs[4]  = mk(20'd0,        1, 1'b0, 5'd0,  0, 0);
        vecs[5]  = mk(20'(1) << 4,  2, 1'b0, 5'd0,  0, 0);
        vecs[6]  = mk(20'd0,        3, 1'b0, 5'd0,  0, 0);
        vecs[7]  = mk((20'(1) << 8) | (20'(1) << 17), 3, 1'b1, 5'd8, 1, 1);
        vecs[8]  = mk(20'(1) << 17, 2, 1'b1, 5'd8,  0, 0);
        vecs[9]  = mk(20'(1) << 17, 1, 1'b1, 5'd17, 1, 0);
        vecs[10] = mk(20'(1) << 15, 3, 1'b1, 5'd15, 1, 0);
        vecs[11] = mk(20'(1) << 15, 3, 1'b1, 5'd15, 1, 1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset row_n",   int'(row_n),   int'(5'b11110));
        chk("reset keycode", int'(keycode), 0);
        chk("reset ready",   int'(ready),   0);
        chk("reset press",   int'(press),   0);

        // Idle scan: rows step every SD clocks and wrap, outputs stay quiet
        rst_n    = 1'b1;
        idle_bad = 0;
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_row = ~(5'b00001 << ((c / SD) % 5));
            chk("scan row_n", int'(row_n), int'(exp_row));
            if (ready || press) idle_bad++;
        end
        chk("idle outputs active cycles", idle_bad, 0);

        // Table-driven key patterns, each starting just after a frame end
        for (int i = 0; i < 11; i++) begin
            run_window(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-dwell with key 15 accepted and still held
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst ready",   int'(ready),   0);
        chk("async rst keycode", int'(keycode), 0);
        chk("async rst press",   int'(press),   0);
        chk("async rst row_n",   int'(row_n),   int'(5'b11110));
        @(negedge clk);
        chk("in rst press", int'(press), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run_window(vecs[11], "reaccept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the board's 5×4 matrix keypad and debounces it, presenting one `keycode`/`ready` pair to `piano_keypad`, which sits directly downstream. Rows are driven active-low one at a time. Columns are synchronized and sampled, and the result is accepted only after it is identical for several consecutive full-matrix frames. It also emits a single-cycle `press` strobe for every new debounced key.

## Interface
- `SCAN_DIV`, default 50000: clocks each row is driven per dwell; ≥4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical frames required to accept a change; 1..15.
- `clk  input  1`: system clock; all logic on its rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `col_n  input  4`: column lines, active-low (pulled up externally), asynchronous to `clk`.
- `row_n  output  5`: row drive, one-hot active-low.
- `keycode  output  5`: debounced key code, 0..19.
- `ready  output  1`: level; high while a debounced key is held.
- `press  output  1`: one-cycle strobe when a new debounced key is accepted.

## Operation
- **Synchronizer:** `col_n` passes through a 2-flop synchronizer before any use.
- **Row drive:** `row_n = ~(1 << row)`. `row` runs 0..4 and advances after `SCAN_DIV` clocks, wrapping 4→0.
- **Sampling:** on the last clock of each row dwell, the synchronized columns are sampled.
  - If any column is low and no key has yet been recorded this frame, record `code = row*4 + c`, where c is the lowest-indexed low column.
  - The first hit in a frame wins: the lowest code among simultaneously pressed keys. No other multi-key resolution is made.
- **Frame end:** on the sample clock of row 4, frame result = (hit, code); the hit/code accumulator then clears.
- **Debounce FSM:** holds candidate (hit, code) and a stability counter `cnt` of 4 bits.
  - If the frame result equals the candidate, increment `cnt`, saturating at `DEBOUNCE_SCANS`.
  - Otherwise, candidate ← result and `cnt` ← 1.
  - Two no-key results compare equal regardless of code.
- **Accept:** when `cnt` reaches `DEBOUNCE_SCANS` and the candidate differs from the debounced state, the debounced state ← candidate.
  - `ready` = debounced hit.
  - `keycode` = debounced code when hit, otherwise 0.
- **`press` strobe:** high for exactly one clock on every accept where the new state is hit. This covers none→key and direct keyA→keyB transitions. There is no strobe on release.
- **Holding a key:** a held key never re-strobes `press`. `ready` and `keycode` stay constant as long as frames agree.
- **Glitch rejection:** a result that differs for fewer than `DEBOUNCE_SCANS` frames never changes the outputs.

## Timing
- **Reset values** (async on `rst_n` low, regardless of clock):
  - `row_n` = 5'b11110
  - `keycode` = 0, `ready` = 0, `press` = 0
  - `row` = 0, dwell counter = 0, `cnt` = 0, candidate = none, debounced = none, synchronizer flops = 4'b1111
- **Reset release:** scanning starts on the first rising edge after `rst_n` goes high.
- **Reset mid-operation:**
  - All state clears immediately.
  - `ready` drops asynchronously.
  - `press` is never emitted by reset.
- **Frame and edge timing:**
  - Frame length is 5·`SCAN_DIV` clocks.
  - The `row_n` change and the dwell counter wrap occur on the same edge.
  - Column sampling happens `SCAN_DIV`−1 clocks after the row drive changes, which gives the matrix settle time.
- **Accept latency:** a key held stable from before a frame's row-0 dwell is accepted at the row-4 sample of the `DEBOUNCE_SCANS`-th frame.
  - `ready`, `keycode` and `press` update together, registered, one clock after that sample edge.
  - Release uses the same latency.
- **Sync delay:** the 2-flop synchronizer adds 2 clocks of column delay. A column must therefore be stable at least 2 clocks before the sample edge to be seen.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, so one frame = 20 clocks.

- **Reset and scan:** hold `rst_n` low → `row_n`=11110 and all outputs 0. Release, no keys pressed → `row_n` steps 11110,11101,11011,10111,01111 every 4 clocks and wraps. `ready` and `press` stay 0.
- **Single key accept:** pull `col_n[1]` low only while `row_n[3]`=0, held from frame start → after the 3rd frame, `keycode`=13, `ready`=1, `press` high for exactly 1 clock. Hold 5 more frames → no further `press`.
- **Release:** release the key from the previous scenario → after 3 frames, `ready`=0 and `keycode`=0, with no `press`.
- **Glitch rejection:** assert key 4 (row 1, col 0) for 2 frames, then release → `ready` never rises and `press` is never emitted.
- **Multi-key and direct change:**
  - Hold keys 8 and 17 together → debounced `keycode`=8.
  - Release 8 while keeping 17 → 3 frames later `keycode`=17, `ready` stays 1, `press` pulses once.
- **Async reset mid-operation:** with key 15 accepted, drop `rst_n` mid-dwell → `ready`, `keycode` and `press` go to 0 before the next clock edge. After release with the key still held, it is re-accepted 3 frames later with one `press`.
